// File: rtl/alu_seq.sv
// alu_seq: registered N-bit ALU with flag register and shift-add MUL; in clk rst start op s a b, out result flags{Z,N,C,V} busy done err
module alu_seq #(
  parameter int N = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic         s,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam int CW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, FIN = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  logic [1:0]    state_q, state_d;
  logic [N-1:0]  result_q, result_d, ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic [3:0]    flags_q, flags_d;
  logic          done_q, done_d, err_q, err_d, s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sub, arith, cin, v, illegal;
  logic [N-1:0]  bb, r, acc_nx;
  logic [N:0]    sum;
  logic [3:0]    nf;
  assign sub     = op == 4'd1 || op == 4'd3 || op == 4'd8;
  assign arith   = op <= 4'd3 || op == 4'd8;
  assign bb      = sub ? ~b : b;
  assign cin     = (op == 4'd2 || op == 4'd3) ? flags_q[1] : sub;
  assign sum     = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, cin};
  assign r       = arith ? sum[N-1:0] : op == 4'd4 ? a & b : op == 4'd5 ? a | b : op == 4'd6 ? a ^ b : b;
  assign v       = (a[N-1] == bb[N-1]) && (r[N-1] != a[N-1]);
  assign nf      = {r == '0, r[N-1], arith ? sum[N] : flags_q[1], arith ? v : flags_q[0]};
  assign illegal = op > 4'd9 || (op == 4'd9 && !MUL_EN);
  assign acc_nx  = acc_q + (mb_q[0] ? ma_q : '0);
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    if (state_q == IDLE) begin
      if (start && illegal) begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end else if (start && op == 4'd9) begin
        state_d = MUL;
        ma_d    = a;
        mb_d    = b;
        acc_d   = '0;
        cnt_d   = '0;
        s_d     = s;
      end else if (start) begin
        done_d   = 1'b1;
        result_d = op == 4'd8 ? result_q : r;
        flags_d  = (s || op == 4'd8) ? nf : flags_q;
      end
    end else if (state_q == MUL) begin
      acc_d = acc_nx;
      ma_d  = ma_q << 1;
      mb_d  = mb_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d  = FIN;
        result_d = acc_nx;
        done_d   = 1'b1;
        flags_d  = s_q ? {acc_nx == '0, acc_nx[N-1], flags_q[1:0]} : flags_q;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      s_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      s_q      <= s_d;
    end
  end
  assign result = result_q;
  assign flags  = flags_q;
  assign busy   = state_q == MUL;
  assign done   = done_q;
  assign err    = err_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: random and directed checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int N = 32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start1 = 1'b0, s = 1'b0;
  logic [3:0] op = '0;
  logic [N-1:0] a = '0, b = '0;
  logic [N-1:0] result, result1;
  logic [3:0] flags, flags1;
  logic busy, done, err, busy1, done1, err1;
  int errors = 0, checks = 0;
  alu_seq #(.N(N), .MUL_EN(1'b1)) u0 (.clk(clk), .rst(rst), .start(start), .op(op), .s(s), .a(a), .b(b),
    .result(result), .flags(flags), .busy(busy), .done(done), .err(err));
  alu_seq #(.N(N), .MUL_EN(1'b0)) u1 (.clk(clk), .rst(rst), .start(start1), .op(op), .s(s), .a(a), .b(b),
    .result(result1), .flags(flags1), .busy(busy1), .done(done1), .err(err1));
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  // Reference: true integer results, carry/borrow and signed overflow from wide arithmetic
  function automatic logic [35:0] alu_ref(logic [3:0] o, logic [31:0] x, logic [31:0] y, logic [3:0] f);
    longint ux = longint'(x), uy = longint'(y), sx = longint'($signed(x)), sy = longint'($signed(y));
    longint ci = longint'(f[1]), ur = 0, sr = 0;
    logic [31:0] r;
    logic c = f[1], v = f[0];
    bit is_sub = o == 4'd1 || o == 4'd3 || o == 4'd8;
    case (o)
      4'd0: begin ur = ux + uy; sr = sx + sy; end
      4'd1, 4'd8: begin ur = ux - uy; sr = sx - sy; end
      4'd2: begin ur = ux + uy + ci; sr = sx + sy + ci; end
      4'd3: begin ur = ux - uy - (1 - ci); sr = sx - sy - (1 - ci); end
      default: ;
    endcase
    case (o)
      4'd4: r = x & y;
      4'd5: r = x | y;
      4'd6: r = x ^ y;
      4'd7: r = y;
      default: begin
        r = ur[31:0];
        c = is_sub ? ur >= 0 : (ur >>> 32) != 0;
        v = sr != longint'($signed(r));
      end
    endcase
    return {r == 32'd0, r[31], c, v, r};
  endfunction
  logic [31:0] m_res, m_prod;
  logic [3:0] m_fl;
  int m_cnt;
  bit m_fin, m_done, m_err, m_s;
  logic [35:0] t_ref;
  assign t_ref = alu_ref(op, a, b, m_fl);
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_res <= '0; m_fl <= '0; m_cnt <= 0; m_fin <= 0; m_done <= 0; m_err <= 0; m_s <= 0; m_prod <= '0;
    end else begin
      m_done <= 0;
      m_err <= 0;
      if (m_fin) m_fin <= 0;
      else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_res <= m_prod;
          if (m_s) m_fl <= {m_prod == 32'd0, m_prod[31], m_fl[1:0]};
          m_done <= 1;
          m_fin <= 1;
        end
      end else if (start) begin
        if (op > 4'd9) begin
          m_done <= 1;
          m_err <= 1;
        end else if (op == 4'd9) begin
          m_prod <= a * b;
          m_cnt <= N;
          m_s <= s;
        end else begin
          m_done <= 1;
          if (op != 4'd8) m_res <= t_ref[31:0];
          if (s || op == 4'd8) m_fl <= t_ref[35:32];
        end
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      chk("result", result, m_res);
      chk("flags", flags, m_fl);
      chk("busy", busy, m_cnt > 0);
      chk("done", done, m_done);
      chk("err", err, m_err);
    end
  end
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic sv);
    start = 1; op = o; a = x; b = y; s = sv;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_done(input bit poke);
    int i = 0;
    while (!done && i < 100) begin
      if (poke && busy && $urandom_range(0, 3) == 0) begin
        start = 1; op = 4'($urandom); a = $urandom; b = $urandom;
      end
      @(posedge clk); #1;
      start = 0;
      i++;
    end
    chk("done_timeout", done, 1'b1);
  endtask
  task automatic next; @(posedge clk); #1; endtask
  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int nb, cyc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0); chk("rst_flags", flags, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0);
    rst = 0;
    next;
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 1);
    chk("add_done", done, 1); chk("add_result", result, 32'd0); chk("add_flags", flags, 4'b1010);
    next;
    chk("add_done_width", done, 0);
    issue(4'd1, 32'h8000_0000, 32'd1, 1);
    chk("sub_result", result, 32'h7FFF_FFFF); chk("sub_flags", flags, 4'b0011);
    next;
    issue(4'd8, 32'd3, 32'd3, 0);
    chk("cmp_result", result, 32'h7FFF_FFFF); chk("cmp_flags", flags, 4'b1010);
    next;
    issue(4'd2, 32'd5, 32'd6, 1);
    chk("adc_result", result, 32'd12); chk("adc_flags", flags, 4'b0000);
    next;
    issue(4'd3, 32'd5, 32'd5, 1);
    chk("sbc_result", result, 32'hFFFF_FFFF); chk("sbc_flags", flags, 4'b0100);
    next;
    issue(4'd1, 32'h8000_0000, 32'd1, 1);
    next;
    issue(4'd9, 32'h1_0000, 32'h1_0000, 1);
    nb = 0; cyc = 0;
    while (!done && cyc < 100) begin
      if (busy) nb++;
      if (cyc == 5) begin start = 1; op = 4'd0; a = 32'd1; b = 32'd1; s = 1; end
      @(posedge clk); #1;
      start = 0;
      cyc++;
    end
    chk("mul_busy_cycles", nb, 32); chk("mul_done_cycle", cyc, 32); chk("mul_done", done, 1);
    chk("mul_busy_end", busy, 0); chk("mul_result", result, 32'd0); chk("mul_flags", flags, 4'b1011);
    next;
    chk("mul_done_width", done, 0);
    issue(4'd12, 32'd1, 32'd2, 1);
    chk("ill_done", done, 1); chk("ill_err", err, 1); chk("ill_result", result, 0); chk("ill_flags", flags, 4'b1011);
    next;
    chk("ill_err_width", err, 0);
    issue(4'd4, 32'hF0, 32'h0F, 0);
    chk("and_result", result, 0); chk("and_flags", flags, 4'b1011); chk("and_err", err, 0);
    next;
    op = 4'd0; a = 32'd2; b = 32'd3; s = 1; start1 = 1;
    next;
    start1 = 0;
    chk("u1_add_result", result1, 32'd5);
    next;
    op = 4'd9; a = 32'd7; b = 32'd9; s = 1; start1 = 1;
    next;
    start1 = 0;
    chk("u1_mul_done", done1, 1); chk("u1_mul_err", err1, 1); chk("u1_mul_busy", busy1, 0);
    chk("u1_mul_result", result1, 32'd5); chk("u1_mul_flags", flags1, 4'b0000);
    next;
    chk("u1_err_width", err1, 0);
    for (int k = 0; k < 250; k++) begin
      issue(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 1'($urandom));
      wait_done(1);
      next;
    end
    issue(4'd1, 32'd0, 32'd1, 1);
    next;
    issue(4'd9, 32'd7, 32'd9, 1);
    repeat (9) next;
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0); chk("arst_result", result, 0); chk("arst_flags", flags, 0); chk("arst_done", done, 0);
    @(negedge clk);
    rst = 0;
    next;
    issue(4'd0, 32'd2, 32'd2, 1);
    chk("post_rst_add", result, 32'd4); chk("post_rst_done", done, 1);
    next;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
